// File: rtl/clock_display_scan.sv
// clock_display_scan: captures hour/min/sec, converts them to BCD and scans a 6-digit 7-segment display.
// Latency: load to committed digits = 7 core edges; the new value appears on seg_n on the following edge.
// Backpressure: none; a load while busy is dropped and the in-flight conversion continues untouched.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   load, hour/min/sec  one-cycle capture strobe and binary time fields
//   busy                high while a conversion is in flight
//   seg_n, dig_n, dp_n  active-low segments {g..a}, one-hot digit enable (bit 0 = sec ones), decimal point
//
// Optional feature: define CLOCK_DP_BLINK_EN to light the decimal points on digits 2 and 4
// whenever the last committed seconds value is even (separator blink). Undefined: dp_n is tied high.

module clock_display_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int CONV_BITS = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    output logic       busy,
    output logic [6:0] seg_n,
    output logic [5:0] dig_n,
    output logic       dp_n
);

    localparam int CW = (CONV_BITS > 1) ? $clog2(CONV_BITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);

    // Internal digit codes: 0..9 are decimal digits, plus two symbols.
    localparam logic [3:0] CODE_BLANK = 4'hA;
    localparam logic [3:0] CODE_DASH  = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [5:0]      hr_bin_q, hr_bin_d;
    logic [5:0]      mn_bin_q, mn_bin_d;
    logic [5:0]      sc_bin_q, sc_bin_d;
    logic [7:0]      hr_bcd_q, hr_bcd_d;
    logic [7:0]      mn_bcd_q, mn_bcd_d;
    logic [7:0]      sc_bcd_q, sc_bcd_d;
    logic            hr_bad_q, hr_bad_d;
    logic            mn_bad_q, mn_bad_d;
    logic            sc_bad_q, sc_bad_d;
    logic [5:0][3:0] disp_q, disp_d;
    logic            busy_q, busy_d;

    logic [PW-1:0]   presc_q, presc_d;
    logic [2:0]      idx_q, idx_d;
    logic [6:0]      seg_n_q, seg_n_d;
    logic [5:0]      dig_n_q, dig_n_d;

    // One double-dabble iteration: add 3 to any nibble >= 5, then shift
    // {bcd, bin} left by one so the binary MSB enters the BCD LSB.
    function automatic logic [13:0] dd_step(input logic [7:0] bcd, input logic [5:0] bin);
        logic [7:0] adj;
        adj = bcd;
        if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
        if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
        return {adj[6:0], bin, 1'b0};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:      s = 7'b1000000;
            4'd1:      s = 7'b1111001;
            4'd2:      s = 7'b0100100;
            4'd3:      s = 7'b0110000;
            4'd4:      s = 7'b0011001;
            4'd5:      s = 7'b0010010;
            4'd6:      s = 7'b0000010;
            4'd7:      s = 7'b1111000;
            4'd8:      s = 7'b0000000;
            4'd9:      s = 7'b0010000;
            CODE_DASH: s = 7'b0111111;
            default:   s = 7'b1111111;
        endcase
        return s;
    endfunction

`ifdef CLOCK_DP_BLINK_EN
    logic dp_arm_q, dp_arm_d;   // captured: sec in range and even
    logic dp_on_q,  dp_on_d;    // committed copy that drives the display
    logic dp_n_q,   dp_n_d;
`endif

    // ------------------------------------------------------------------
    // Capture / conversion / commit
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hr_bin_d = hr_bin_q;
        mn_bin_d = mn_bin_q;
        sc_bin_d = sc_bin_q;
        hr_bcd_d = hr_bcd_q;
        mn_bcd_d = mn_bcd_q;
        sc_bcd_d = sc_bcd_q;
        hr_bad_d = hr_bad_q;
        mn_bad_d = mn_bad_q;
        sc_bad_d = sc_bad_q;
        disp_d   = disp_q;
`ifdef CLOCK_DP_BLINK_EN
        dp_arm_d = dp_arm_q;
        dp_on_d  = dp_on_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d  = ST_CONV;
                    cnt_d    = '0;
                    hr_bin_d = {1'b0, hour};
                    mn_bin_d = min;
                    sc_bin_d = sec;
                    hr_bcd_d = '0;
                    mn_bcd_d = '0;
                    sc_bcd_d = '0;
                    hr_bad_d = (hour > 5'd23);
                    mn_bad_d = (min  > 6'd59);
                    sc_bad_d = (sec  > 6'd59);
`ifdef CLOCK_DP_BLINK_EN
                    dp_arm_d = (sec <= 6'd59) && !sec[0];
`endif
                end
            end
            ST_CONV: begin
                {hr_bcd_d, hr_bin_d} = dd_step(hr_bcd_q, hr_bin_q);
                {mn_bcd_d, mn_bin_d} = dd_step(mn_bcd_q, mn_bin_q);
                {sc_bcd_d, sc_bin_d} = dd_step(sc_bcd_q, sc_bin_q);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(CONV_BITS - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                disp_d[0] = sc_bad_q ? CODE_DASH : sc_bcd_q[3:0];
                disp_d[1] = sc_bad_q ? CODE_DASH : sc_bcd_q[7:4];
                disp_d[2] = mn_bad_q ? CODE_DASH : mn_bcd_q[3:0];
                disp_d[3] = mn_bad_q ? CODE_DASH : mn_bcd_q[7:4];
                disp_d[4] = hr_bad_q ? CODE_DASH : hr_bcd_q[3:0];
                disp_d[5] = hr_bad_q ? CODE_DASH : hr_bcd_q[7:4];
`ifdef CLOCK_DP_BLINK_EN
                dp_on_d   = dp_arm_q;
`endif
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Digit scan. Segments are looked up for the index being entered so
    // dig_n and seg_n switch together on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
        // disp_q (not disp_d): a fresh commit reaches the pins one edge later.
        seg_n_d = seg_decode(disp_q[idx_d]);
        dig_n_d = ~(6'b000001 << idx_d);
`ifdef CLOCK_DP_BLINK_EN
        dp_n_d  = !(dp_on_q && ((idx_d == 3'd2) || (idx_d == 3'd4)));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hr_bin_q <= '0;
            mn_bin_q <= '0;
            sc_bin_q <= '0;
            hr_bcd_q <= '0;
            mn_bcd_q <= '0;
            sc_bcd_q <= '0;
            hr_bad_q <= 1'b0;
            mn_bad_q <= 1'b0;
            sc_bad_q <= 1'b0;
            disp_q   <= {6{CODE_BLANK}};
            busy_q   <= 1'b0;
            presc_q  <= '0;
            idx_q    <= 3'd0;
            seg_n_q  <= 7'h7F;
            dig_n_q  <= 6'b111110;
`ifdef CLOCK_DP_BLINK_EN
            dp_arm_q <= 1'b0;
            dp_on_q  <= 1'b0;
            dp_n_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hr_bin_q <= hr_bin_d;
            mn_bin_q <= mn_bin_d;
            sc_bin_q <= sc_bin_d;
            hr_bcd_q <= hr_bcd_d;
            mn_bcd_q <= mn_bcd_d;
            sc_bcd_q <= sc_bcd_d;
            hr_bad_q <= hr_bad_d;
            mn_bad_q <= mn_bad_d;
            sc_bad_q <= sc_bad_d;
            disp_q   <= disp_d;
            busy_q   <= busy_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            seg_n_q  <= seg_n_d;
            dig_n_q  <= dig_n_d;
`ifdef CLOCK_DP_BLINK_EN
            dp_arm_q <= dp_arm_d;
            dp_on_q  <= dp_on_d;
            dp_n_q   <= dp_n_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign seg_n = seg_n_q;
    assign dig_n = dig_n_q;
`ifdef CLOCK_DP_BLINK_EN
    assign dp_n  = dp_n_q;
`else
    assign dp_n  = 1'b1;
`endif

endmodule

// File: tb/tb_clock_display_scan.sv
// tb_clock_display_scan: scoreboard bench for clock_display_scan with a short scan divider.
// Latency: expected digits are queued at load and compared once busy falls and the display settles.
// Backpressure: exercises dropped loads while busy and a reset that aborts a conversion.

module tb_clock_display_scan;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       busy;
    logic [6:0] seg_n;
    logic [5:0] dig_n;
    logic       dp_n;

    clock_display_scan #(.SCAN_DIV(SD), .CONV_BITS(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .hour  (hour),
        .min   (min),
        .sec   (sec),
        .busy  (busy),
        .seg_n (seg_n),
        .dig_n (dig_n),
        .dp_n  (dp_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0][6:0] segs;
        logic [5:0]      dpn;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            11: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic exp_t model(input int h, input int m, input int s);
        exp_t e;
        e.segs[5] = (h > 23) ? seg_ref(11) : seg_ref(h / 10);
        e.segs[4] = (h > 23) ? seg_ref(11) : seg_ref(h % 10);
        e.segs[3] = (m > 59) ? seg_ref(11) : seg_ref(m / 10);
        e.segs[2] = (m > 59) ? seg_ref(11) : seg_ref(m % 10);
        e.segs[1] = (s > 59) ? seg_ref(11) : seg_ref(s / 10);
        e.segs[0] = (s > 59) ? seg_ref(11) : seg_ref(s % 10);
        e.dpn     = 6'h3F;
`ifdef CLOCK_DP_BLINK_EN
        if (s <= 59 && (s % 2) == 0) begin
            e.dpn[2] = 1'b0;
            e.dpn[4] = 1'b0;
        end
`endif
        return e;
    endfunction

    // Let the scan settle, then watch one full rotation and record each digit.
    task automatic check_display(input string tag, input exp_t e);
        logic [5:0][6:0] segs;
        logic [5:0]      dpn;
        logic [5:0]      seen;
        logic [5:0]      oh;
        segs = '1;
        dpn  = '1;
        seen = '0;
        repeat (6 * SD + 2) @(negedge clk);
        for (int i = 0; i < 6 * SD; i++) begin
            @(negedge clk);
            for (int d = 0; d < 6; d++) begin
                oh = ~(6'b000001 << d);
                if (dig_n === oh) begin
                    segs[d] = seg_n;
                    dpn[d]  = dp_n;
                    seen[d] = 1'b1;
                end
            end
        end
        chk({tag, "_seen"}, 32'(seen), 32'h3F);
        for (int d = 0; d < 6; d++) begin
            chk($sformatf("%s_dig%0d", tag, d), 32'(segs[d]), 32'(e.segs[d]));
        end
        chk({tag, "_dp"}, 32'(dpn), 32'(e.dpn));
    endtask

    // Drive one load, optionally a second (ignored) load on busy cycle `intrude`,
    // measure the busy window and then compare the display against the scoreboard.
    task automatic do_load(input string tag, input int h, input int m, input int s, input int intrude);
        int   n;
        int   guard;
        exp_t e;
        @(negedge clk);
        hour = 5'(h);
        min  = 6'(m);
        sec  = 6'(s);
        load = 1'b1;
        sb_q.push_back(model(h, m, s));
        @(negedge clk);
        load  = 1'b0;
        n     = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 20) begin
            n++;
            if (n == intrude) begin
                sec  = 6'(s + 1);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        load = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(n), 32'd7);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_display(tag, e);
        end
        chk({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t       blank;
        int         cnt;
        logic [5:0] prev;
        logic [5:0] oh;
        blank.segs = '1;
        blank.dpn  = '1;

        rst  = 1'b1;
        load = 1'b0;
        hour = '0;
        min  = '0;
        sec  = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dig", 32'(dig_n), 32'h3E);
        chk("rst_seg", 32'(seg_n), 32'h7F);
        chk("rst_dp", 32'(dp_n), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Scan rotation: each digit dwells SD clocks, order 0..5 then back to 0.
        for (int step = 1; step <= 6; step++) begin
            cnt  = 0;
            prev = dig_n;
            do begin
                @(negedge clk);
                cnt++;
            end while (dig_n === prev && cnt < 100);
            oh = ~(6'b000001 << (step % 6));
            chk($sformatf("scan_dwell%0d", step), 32'(cnt), 32'(SD));
            chk($sformatf("scan_dig%0d", step), 32'(dig_n), 32'(oh));
            chk($sformatf("scan_seg%0d", step), 32'(seg_n), 32'h7F);
            chk($sformatf("scan_busy%0d", step), 32'(busy), 32'd0);
        end
        check_display("blank", blank);

        do_load("t235958", 23, 59, 58, 0);
        do_load("t000000", 0, 0, 0, 2);
        do_load("t_range", 24, 60, 7, 0);
        do_load("t070509", 7, 5, 9, 0);

        // Reset on the third conversion cycle aborts and blanks the display.
        @(negedge clk);
        hour = 5'd12;
        min  = 6'd34;
        sec  = 6'd56;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dig", 32'(dig_n), 32'h3E);
        chk("abort_seg", 32'(seg_n), 32'h7F);
        chk("abort_dp", 32'(dp_n), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        check_display("abort_blank", blank);
        do_load("t010203", 1, 2, 3, 0);

        do_load("t_sec10", 12, 34, 10, 0);
        do_load("t_sec11", 12, 34, 11, 0);
        do_load("t_sec_bad", 12, 34, 62, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
